// File: rtl/cacheline_adapter.sv
// Cache-line to burst-memory adapter.
// Accepts 256-bit line fill/writeback requests from the cache and turns each one
// into a 4-beat burst on a 64-bit memory port, answering with a one-cycle mem_resp.
module cacheline_adapter #(
    parameter int unsigned CACHE_LINE_SIZE = 256,
    parameter int unsigned BURST_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    // Cache side
    input  logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [CACHE_LINE_SIZE-1:0] mem_wdata,
    output logic [CACHE_LINE_SIZE-1:0] mem_rdata,
    output logic                       mem_resp,

    // Burst memory side
    output logic [ADDR_WIDTH-1:0]      bmem_addr,
    output logic                       bmem_read,
    output logic                       bmem_write,
    output logic [BURST_WIDTH-1:0]     bmem_wdata,
    input  logic                       bmem_ready,
    input  logic [BURST_WIDTH-1:0]     bmem_rdata,
    input  logic                       bmem_rvalid
);

    localparam int unsigned BURSTS = CACHE_LINE_SIZE / BURST_WIDTH;
    localparam int unsigned OFFSET = $clog2(CACHE_LINE_SIZE / 8);
    localparam int unsigned BEAT_W = $clog2(BURSTS);

    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdReq,
        StRdWait,
        StResp
    } state_e;

    state_e                     state_q, state_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    // Shared line buffer: holds the write line during WR, collects beats during RD_WAIT.
    logic [CACHE_LINE_SIZE-1:0] line_q, line_d;
    logic [CACHE_LINE_SIZE-1:0] mem_rdata_q, mem_rdata_d;
    logic                       mem_resp_q, mem_resp_d;
    logic [ADDR_WIDTH-1:0]      bmem_addr_q, bmem_addr_d;
    logic                       bmem_read_q, bmem_read_d;
    logic                       bmem_write_q, bmem_write_d;
    logic [BURST_WIDTH-1:0]     bmem_wdata_q, bmem_wdata_d;

    // Next-state and next-output logic; outputs are computed one cycle ahead so
    // every output leaves the block straight from a flop.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        line_d       = line_q;
        mem_rdata_d  = mem_rdata_q;
        mem_resp_d   = 1'b0;
        bmem_addr_d  = bmem_addr_q;
        bmem_read_d  = bmem_read_q;
        bmem_write_d = bmem_write_q;
        bmem_wdata_d = bmem_wdata_q;

        case (state_q)
            StIdle: begin
                // Write wins when both requests are raised together.
                if (mem_write) begin
                    state_d      = StWr;
                    beat_d       = '0;
                    line_d       = mem_wdata;
                    bmem_addr_d  = mem_addr & ALIGN_MASK;
                    bmem_write_d = 1'b1;
                    bmem_wdata_d = mem_wdata[BURST_WIDTH-1:0];
                end else if (mem_read) begin
                    state_d     = StRdReq;
                    beat_d      = '0;
                    bmem_addr_d = mem_addr & ALIGN_MASK;
                    bmem_read_d = 1'b1;
                end
            end

            StWr: begin
                if (bmem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d      = StResp;
                        bmem_write_d = 1'b0;
                        mem_resp_d   = 1'b1;
                    end else begin
                        beat_d       = beat_q + BEAT_W'(1);
                        bmem_wdata_d = line_q[int'(beat_d) * BURST_WIDTH +: BURST_WIDTH];
                    end
                end
            end

            StRdReq: begin
                if (bmem_ready) begin
                    state_d     = StRdWait;
                    bmem_read_d = 1'b0;
                end
            end

            StRdWait: begin
                if (bmem_rvalid) begin
                    line_d[int'(beat_q) * BURST_WIDTH +: BURST_WIDTH] = bmem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        state_d     = StResp;
                        mem_resp_d  = 1'b1;
                        mem_rdata_d = line_d;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything, even mid-burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            line_q       <= '0;
            mem_rdata_q  <= '0;
            mem_resp_q   <= 1'b0;
            bmem_addr_q  <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            line_q       <= line_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_resp_q   <= mem_resp_d;
            bmem_addr_q  <= bmem_addr_d;
            bmem_read_q  <= bmem_read_d;
            bmem_write_q <= bmem_write_d;
            bmem_wdata_q <= bmem_wdata_d;
        end
    end

    assign mem_rdata  = mem_rdata_q;
    assign mem_resp   = mem_resp_q;
    assign bmem_addr  = bmem_addr_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: a per-cycle vector table for the
// plain write/read/priority flows, plus directed stall and mid-burst reset sequences.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    // One row per cycle: outputs expected in that cycle, then inputs driven for its edge.
    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic         ready;
        logic         rvalid;
        logic [63:0]  rdata;
        logic         e_resp;
        logic         e_bread;
        logic         e_bwrite;
        logic [31:0]  e_baddr;
        logic [63:0]  e_bwdata;
        logic [255:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    logic         q_rd, q_wr;
    logic [31:0]  q_addr, q_baddr;
    logic [255:0] q_wdata;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] L1 = {64'hD, 64'hC, 64'hB, 64'hA};
    localparam logic [255:0] L2 = {64'h8, 64'h7, 64'h6, 64'h5};
    localparam logic [255:0] R1 = {64'h4, 64'h3, 64'h2, 64'h1};
    localparam logic [255:0] R2 = {64'hC, 64'hB, 64'hA, 64'h9};
    localparam logic [255:0] R3 = {64'h44, 64'h33, 64'h22, 64'h11};

    task automatic add(input logic ready, input logic rvalid, input logic [63:0] rdata,
                       input logic e_resp, input logic e_bread, input logic e_bwrite,
                       input logic [63:0] e_bwdata, input logic [255:0] e_rdata);
        vec_t v;
        v.rd       = q_rd;
        v.wr       = q_wr;
        v.addr     = q_addr;
        v.wdata    = q_wdata;
        v.ready    = ready;
        v.rvalid   = rvalid;
        v.rdata    = rdata;
        v.e_resp   = e_resp;
        v.e_bread  = e_bread;
        v.e_bwrite = e_bwrite;
        v.e_baddr  = q_baddr;
        v.e_bwdata = e_bwdata;
        v.e_rdata  = e_rdata;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic ready,
                         input logic rvalid, input logic [63:0] rdata);
        mem_read    = rd;
        mem_write   = wr;
        mem_addr    = addr;
        mem_wdata   = wdata;
        bmem_ready  = ready;
        bmem_rvalid = rvalid;
        bmem_rdata  = rdata;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 64'h0);

        // ---- vector table ----
        q_rd = 1'b0; q_wr = 1'b0; q_addr = '0; q_wdata = '0; q_baddr = '0;
        add(0, 0, 0,        0, 0, 0, 0, '0);     // reset state
        // Write, no stalls
        q_wr = 1'b1; q_addr = 32'h1000_0024; q_wdata = L1; q_baddr = 32'h1000_0020;
        add(1, 0, 0,        0, 0, 0, 0,     '0);
        add(1, 0, 0,        0, 0, 1, 64'hA, '0);
        add(1, 0, 0,        0, 0, 1, 64'hB, '0);
        add(1, 0, 0,        0, 0, 1, 64'hC, '0);
        add(1, 0, 0,        0, 0, 1, 64'hD, '0);
        q_wr = 1'b0;
        add(1, 0, 0,        1, 0, 0, 0, '0);
        add(0, 1, 64'hDEAD, 0, 0, 0, 0, '0);     // stray rvalid in IDLE
        add(0, 0, 0,        0, 0, 0, 0, '0);
        // Read with a command stall and a 2-cycle gap after beat 2
        q_rd = 1'b1; q_addr = 32'h0000_0040; q_baddr = 32'h0000_0040;
        add(0, 0, 0,        0, 0, 0, 0, '0);
        add(0, 0, 0,        0, 1, 0, 0, '0);
        add(1, 0, 0,        0, 1, 0, 0, '0);
        add(1, 1, 64'h1,    0, 0, 0, 0, '0);
        add(0, 1, 64'h2,    0, 0, 0, 0, '0);
        add(0, 0, 0,        0, 0, 0, 0, '0);
        add(0, 0, 0,        0, 0, 0, 0, '0);
        add(0, 1, 64'h3,    0, 0, 0, 0, '0);
        add(0, 1, 64'h4,    0, 0, 0, 0, '0);
        q_rd = 1'b0;
        add(0, 0, 0,        1, 0, 0, 0, R1);
        add(0, 0, 0,        0, 0, 0, 0, R1);
        // Simultaneous read+write: write first, read afterwards
        q_rd = 1'b1; q_wr = 1'b1; q_addr = 32'h0000_0200; q_wdata = L2; q_baddr = 32'h0000_0200;
        add(1, 0, 0,        0, 0, 0, 0,     R1);
        add(1, 0, 0,        0, 0, 1, 64'h5, R1);
        add(1, 1, 64'hDEAD, 0, 0, 1, 64'h6, R1); // stray rvalid in WR
        add(1, 0, 0,        0, 0, 1, 64'h7, R1);
        add(1, 0, 0,        0, 0, 1, 64'h8, R1);
        q_wr = 1'b0;
        add(1, 0, 0,        1, 0, 0, 0, R1);     // pending read ignored in RESP
        add(1, 0, 0,        0, 0, 0, 0, R1);
        add(1, 0, 0,        0, 1, 0, 0, R1);
        add(1, 1, 64'h9,    0, 0, 0, 0, R1);
        add(1, 1, 64'hA,    0, 0, 0, 0, R1);
        add(1, 1, 64'hB,    0, 0, 0, 0, R1);
        add(1, 1, 64'hC,    0, 0, 0, 0, R1);
        q_rd = 1'b0;
        add(0, 0, 0,        1, 0, 0, 0, R2);
        add(0, 0, 0,        0, 0, 0, 0, R2);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step();
            chk($sformatf("row%0d mem_resp", i),   {255'b0, mem_resp},   {255'b0, tbl[i].e_resp});
            chk($sformatf("row%0d bmem_read", i),  {255'b0, bmem_read},  {255'b0, tbl[i].e_bread});
            chk($sformatf("row%0d bmem_write", i), {255'b0, bmem_write}, {255'b0, tbl[i].e_bwrite});
            chk($sformatf("row%0d mem_rdata", i),  mem_rdata,            tbl[i].e_rdata);
            if (tbl[i].e_bread || tbl[i].e_bwrite)
                chk($sformatf("row%0d bmem_addr", i), {224'b0, bmem_addr}, {224'b0, tbl[i].e_baddr});
            if (tbl[i].e_bwrite)
                chk($sformatf("row%0d bmem_wdata", i), {192'b0, bmem_wdata},
                    {192'b0, tbl[i].e_bwdata});
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ready,
                  tbl[i].rvalid, tbl[i].rdata);
        end

        // ---- write with 2 stall cycles before beat 1 ----
        step();
        drive(1'b0, 1'b1, 32'h3000_0008, L1, 1'b1, 1'b0, 64'h0);
        step();
        chk("stall beat0 data", {192'b0, bmem_wdata}, {192'b0, 64'hA});
        chk("stall addr", {224'b0, bmem_addr}, {224'b0, 32'h3000_0000});
        step();
        chk("stall beat1 data c0", {192'b0, bmem_wdata}, {192'b0, 64'hB});
        bmem_ready = 1'b0;
        step();
        chk("stall beat1 data c1", {192'b0, bmem_wdata}, {192'b0, 64'hB});
        chk("stall beat1 valid c1", {255'b0, bmem_write}, {255'b0, 1'b1});
        step();
        chk("stall beat1 data c2", {192'b0, bmem_wdata}, {192'b0, 64'hB});
        bmem_ready = 1'b1;
        step();
        chk("stall beat2 data", {192'b0, bmem_wdata}, {192'b0, 64'hC});
        chk("stall no early resp", {255'b0, mem_resp}, {255'b0, 1'b0});
        step();
        chk("stall beat3 data", {192'b0, bmem_wdata}, {192'b0, 64'hD});
        step();
        chk("stall resp", {255'b0, mem_resp}, {255'b0, 1'b1});
        chk("stall write done", {255'b0, bmem_write}, {255'b0, 1'b0});
        mem_write = 1'b0;
        step();
        chk("stall resp one cycle", {255'b0, mem_resp}, {255'b0, 1'b0});

        // ---- reset after two accepted write beats, then a clean read ----
        drive(1'b0, 1'b1, 32'h0000_0040, L2, 1'b1, 1'b0, 64'h0);
        step();
        chk("rst beat0", {192'b0, bmem_wdata}, {192'b0, 64'h5});
        step();
        chk("rst beat1", {192'b0, bmem_wdata}, {192'b0, 64'h6});
        step();
        chk("rst beat2", {192'b0, bmem_wdata}, {192'b0, 64'h7});
        rst = 1'b1;
        mem_write = 1'b0;
        step();
        chk("rst bmem_write", {255'b0, bmem_write}, {255'b0, 1'b0});
        chk("rst bmem_read", {255'b0, bmem_read}, {255'b0, 1'b0});
        chk("rst mem_resp", {255'b0, mem_resp}, {255'b0, 1'b0});
        chk("rst mem_rdata", mem_rdata, '0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0080, '0, 1'b1, 1'b0, 64'h0);
        step();
        chk("post-rst read cmd", {255'b0, bmem_read}, {255'b0, 1'b1});
        chk("post-rst read addr", {224'b0, bmem_addr}, {224'b0, 32'h0000_0080});
        chk("post-rst no write", {255'b0, bmem_write}, {255'b0, 1'b0});
        step();
        chk("post-rst cmd once", {255'b0, bmem_read}, {255'b0, 1'b0});
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'h11;
        step();
        bmem_rdata = 64'h22;
        step();
        bmem_rdata = 64'h33;
        step();
        chk("post-rst no early resp", {255'b0, mem_resp}, {255'b0, 1'b0});
        bmem_rdata = 64'h44;
        step();
        chk("post-rst resp", {255'b0, mem_resp}, {255'b0, 1'b1});
        chk("post-rst line", mem_rdata, R3);
        drive(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 64'h0);
        step();
        chk("post-rst resp one cycle", {255'b0, mem_resp}, {255'b0, 1'b0});
        chk("post-rst line held", mem_rdata, R3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
